local_net_interface: RTL and testbench
======================================

Name: local_net_interface

Overview:
- Network interface between a processing element (PE) and the local (L) port of one mesh router.
- Injection path: packs PE requests into single-flit packets, buffers them, and drives the router's L input under the router's L-FIFO full backpressure.
- Ejection path: accepts flits from the router's L output, checks that each flit is addressed to this node, and buffers them for the PE behind a valid/ready handshake.
- Also keeps traffic counters and sticky error flags.

Parameters:
- DATASIZE, 30: flit width. Must equal the router's DATASIZE.
- NODE_ID, 6: this node's 4-bit ID. Must equal the attached router's router_ID.
- INJ_DEPTH, 4: injection FIFO entries. Power of 2.
- EJ_DEPTH, 4: ejection FIFO entries. Power of 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  PE injection request.
- tx_ready  out  1  injection FIFO not full.
- tx_dest  in  4  destination node ID.
- tx_payload  in  DATASIZE-8  payload.
- inj_data  out  DATASIZE  flit to router L_data_in.
- inj_valid  out  1  to router L_valid_in.
- router_full  in  1  from router L-FIFO full.
- ej_data  in  DATASIZE  from router L_data_out.
- ej_valid  in  1  from router L_valid_out.
- rx_valid  out  1  ejection FIFO not empty.
- rx_ready  in  1  PE accepts head flit.
- rx_src  out  4  source ID of head flit.
- rx_payload  out  DATASIZE-8  payload of head flit.
- err_overflow  out  1  sticky: an ejected flit was dropped.
- err_misroute  out  1  sticky: a flit arrived with dest != NODE_ID.
- tx_cnt  out  16  flits injected into the router.
- rx_cnt  out  16  flits delivered to the PE.

Behaviour:
- Flit format:
  - [DATASIZE-1:DATASIZE-4] = dest.
  - [DATASIZE-5:DATASIZE-8] = src.
  - [DATASIZE-9:0] = payload.
  - src is always NODE_ID.
- Reset (rst high at a clk edge) clears both FIFOs, pointers, counters and flags. Reset values:
  - inj_valid = 0, inj_data = 0, rx_valid = 0.
  - tx_ready = 1 in the cycle after reset.
  - err_* = 0, tx_cnt = rx_cnt = 0.
- Reset asserted mid-operation discards all buffered flits; no partial flit is emitted.
- Injection write: when tx_valid && tx_ready, the packed flit is written at the edge.
- tx_ready = !inj_full, combinational from the FIFO occupancy register.
- When inj_full, tx_valid is ignored and nothing is written.
- Injection issue:
  - inj_valid and inj_data are registered.
  - At an edge where the FIFO is non-empty and router_full == 0: pop the head, set inj_valid = 1 and inj_data = head for exactly the next cycle, and increment tx_cnt.
  - Otherwise set inj_valid = 0. inj_data holds its last value.
- Latency from an accepted tx handshake at edge t to inj_valid high is 1 cycle after edge t+1 (first issue edge), given an empty FIFO and router_full low.
- Maximum rate is one flit per cycle.
- A simultaneous push and pop keeps occupancy unchanged, and a push into a full FIFO with a pop in the same cycle is not allowed: tx_ready is already low.
- Self-addressed flits (tx_dest == NODE_ID) are legal and are sent through the router.
- Ejection write: the router has no L backpressure, so every ej_valid cycle is sampled.
- If the ejection FIFO is not full, or a PE pop occurs in the same cycle, the flit is written. Otherwise the flit is dropped and err_overflow is set.
- If the dest field != NODE_ID, err_misroute is set. The flit is still buffered.
- rx_valid = !ej_empty. rx_src and rx_payload come from the head entry, combinationally.
- On rx_valid && rx_ready: pop the entry and increment rx_cnt.
- rx_valid and the head fields remain stable until popped.
- tx_cnt and rx_cnt wrap 0xFFFF -> 0x0000.
- err_* clear only on reset.
- FIFO pointers are log2(DEPTH)+1 bits wide, with wrap-bit full/empty detection.

Test Plan:
- Reset, then single inject:
  - Stimulus: tx_dest=3, tx_payload=0x12345, router_full=0.
  - Required: inj_valid high for one cycle with inj_data = {4'h3, 4'h6, 22'h012345}, and tx_cnt=1.
- Backpressure:
  - Stimulus: router_full=1; push 5 requests back-to-back.
  - Required: 4 accepted; tx_ready low on the 5th; inj_valid stays 0.
  - Then release router_full: 4 consecutive inj_valid cycles in push order; tx_ready returns to 1; tx_cnt=4.
- Ejection delivery:
  - Stimulus: rx_ready=0; 3 flits with dest=6, src=2, 9, 15.
  - Required: rx_valid=1 with rx_src=2.
  - Then rx_ready=1: rx_src sequence 2, 9, 15; rx_cnt=3; err_* remain 0.
- Ejection overflow:
  - Stimulus: rx_ready=0; 5 ej_valid flits.
  - Required: first 4 stored; err_overflow=1 after the 5th; draining yields exactly 4 flits.
  - Variant: rx_ready=1 on the 5th cycle, and the 5th flit is stored with no error.
- Misroute: ej flit with dest=5 -> err_misroute=1, and the flit is still delivered with correct rx_payload.
- Reset mid-traffic and counter wrap:
  - Stimulus: rst with 2 flits queued on each side.
  - Required: next cycle inj_valid=0, rx_valid=0, tx_ready=1.
  - Counter wrap: preload by injecting 65537 flits; tx_cnt=1.

Source files
------------

// File: rtl/local_net_interface.sv
// Network interface between a processing element and the local port of a mesh router:
// packs and buffers injected flits, and buffers and checks ejected flits, with counters and sticky errors.
module local_net_interface #(
  parameter int DATASIZE  = 30,
  parameter int NODE_ID   = 6,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [3:0]          tx_dest,
  input  logic [DATASIZE-9:0] tx_payload,
  output logic [DATASIZE-1:0] inj_data,
  output logic                inj_valid,
  input  logic                router_full,
  input  logic [DATASIZE-1:0] ej_data,
  input  logic                ej_valid,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [3:0]          rx_src,
  output logic [DATASIZE-9:0] rx_payload,
  output logic                err_overflow,
  output logic                err_misroute,
  output logic [15:0]         tx_cnt,
  output logic [15:0]         rx_cnt
);

  localparam int INJ_AW = $clog2(INJ_DEPTH);
  localparam int EJ_AW  = $clog2(EJ_DEPTH);
  localparam logic [3:0]      LP_NODE    = 4'(NODE_ID);
  localparam logic [INJ_AW:0] LP_INJ_ONE = 1;
  localparam logic [EJ_AW:0]  LP_EJ_ONE  = 1;

  // ---------------- injection path ----------------
  logic [DATASIZE-1:0] r_inj_mem [INJ_DEPTH];
  logic [INJ_AW:0]     r_inj_wr_ptr;
  logic [INJ_AW:0]     r_inj_rd_ptr;
  logic [DATASIZE-1:0] r_inj_data;
  logic                r_inj_valid;
  logic [15:0]         r_tx_cnt;

  logic                w_inj_empty;
  logic                w_inj_full;
  logic                w_inj_push;
  logic                w_inj_pop;
  logic [DATASIZE-1:0] w_tx_flit;

  assign w_inj_empty = (r_inj_wr_ptr == r_inj_rd_ptr);
  assign w_inj_full  = (r_inj_wr_ptr[INJ_AW] != r_inj_rd_ptr[INJ_AW]) &&
                       (r_inj_wr_ptr[INJ_AW-1:0] == r_inj_rd_ptr[INJ_AW-1:0]);
  assign w_inj_push  = tx_valid && !w_inj_full;
  assign w_inj_pop   = !w_inj_empty && !router_full;
  assign w_tx_flit   = {tx_dest, LP_NODE, tx_payload};

  assign tx_ready  = !w_inj_full;
  assign inj_data  = r_inj_data;
  assign inj_valid = r_inj_valid;
  assign tx_cnt    = r_tx_cnt;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_inj_push) begin
      r_inj_mem[r_inj_wr_ptr[INJ_AW-1:0]] <= w_tx_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj_wr_ptr <= '0;
      r_inj_rd_ptr <= '0;
      r_inj_data   <= '0;
      r_inj_valid  <= 1'b0;
      r_tx_cnt     <= '0;
    end else begin
      r_inj_valid <= w_inj_pop;
      if (w_inj_push) begin
        r_inj_wr_ptr <= r_inj_wr_ptr + LP_INJ_ONE;
      end
      if (w_inj_pop) begin
        r_inj_rd_ptr <= r_inj_rd_ptr + LP_INJ_ONE;
        r_inj_data   <= r_inj_mem[r_inj_rd_ptr[INJ_AW-1:0]];
        r_tx_cnt     <= r_tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- ejection path ----------------
  // The destination field is checked on arrival and not stored.
  logic [DATASIZE-5:0] r_ej_mem [EJ_DEPTH];
  logic [EJ_AW:0]      r_ej_wr_ptr;
  logic [EJ_AW:0]      r_ej_rd_ptr;
  logic                r_err_overflow;
  logic                r_err_misroute;
  logic [15:0]         r_rx_cnt;

  logic                w_ej_empty;
  logic                w_ej_full;
  logic                w_ej_push;
  logic                w_ej_pop;
  logic                w_ej_misroute;
  logic [DATASIZE-5:0] w_ej_head;

  assign w_ej_empty    = (r_ej_wr_ptr == r_ej_rd_ptr);
  assign w_ej_full     = (r_ej_wr_ptr[EJ_AW] != r_ej_rd_ptr[EJ_AW]) &&
                         (r_ej_wr_ptr[EJ_AW-1:0] == r_ej_rd_ptr[EJ_AW-1:0]);
  assign w_ej_pop      = !w_ej_empty && rx_ready;
  // A pop in the same cycle frees the slot the incoming flit lands in.
  assign w_ej_push     = ej_valid && (!w_ej_full || w_ej_pop);
  assign w_ej_misroute = ej_valid && (ej_data[DATASIZE-1:DATASIZE-4] != LP_NODE);
  assign w_ej_head     = r_ej_mem[r_ej_rd_ptr[EJ_AW-1:0]];

  assign rx_valid     = !w_ej_empty;
  assign rx_src       = w_ej_head[DATASIZE-5:DATASIZE-8];
  assign rx_payload   = w_ej_head[DATASIZE-9:0];
  assign err_overflow = r_err_overflow;
  assign err_misroute = r_err_misroute;
  assign rx_cnt       = r_rx_cnt;

  always_ff @(posedge clk) begin
    if (w_ej_push) begin
      r_ej_mem[r_ej_wr_ptr[EJ_AW-1:0]] <= ej_data[DATASIZE-5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ej_wr_ptr    <= '0;
      r_ej_rd_ptr    <= '0;
      r_err_overflow <= 1'b0;
      r_err_misroute <= 1'b0;
      r_rx_cnt       <= '0;
    end else begin
      if (w_ej_push) begin
        r_ej_wr_ptr <= r_ej_wr_ptr + LP_EJ_ONE;
      end
      if (w_ej_pop) begin
        r_ej_rd_ptr <= r_ej_rd_ptr + LP_EJ_ONE;
        r_rx_cnt    <= r_rx_cnt + 16'd1;
      end
      if (ej_valid && !w_ej_push) begin
        r_err_overflow <= 1'b1;
      end
      if (w_ej_misroute) begin
        r_err_misroute <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_local_net_interface.sv
// Self-checking bench for local_net_interface: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_local_net_interface;

  localparam int DS  = 30;
  localparam int NID = 6;
  localparam int IDP = 4;
  localparam int EDP = 4;
  localparam int PW  = DS - 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [3:0]    tx_dest;
  logic [PW-1:0] tx_payload;
  logic [DS-1:0] inj_data;
  logic          inj_valid;
  logic          router_full;
  logic [DS-1:0] ej_data;
  logic          ej_valid;
  logic          rx_valid;
  logic          rx_ready;
  logic [3:0]    rx_src;
  logic [PW-1:0] rx_payload;
  logic          err_overflow;
  logic          err_misroute;
  logic [15:0]   tx_cnt;
  logic [15:0]   rx_cnt;

  local_net_interface #(
    .DATASIZE(DS), .NODE_ID(NID), .INJ_DEPTH(IDP), .EJ_DEPTH(EDP)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_payload(tx_payload),
    .inj_data(inj_data), .inj_valid(inj_valid), .router_full(router_full),
    .ej_data(ej_data), .ej_valid(ej_valid),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_payload(rx_payload),
    .err_overflow(err_overflow), .err_misroute(err_misroute),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DS-1:0] mkflit(input logic [3:0] d, input logic [3:0] s,
                                           input logic [PW-1:0] p);
    return {d, s, p};
  endfunction

  // ---------------- reference model ----------------
  logic [DS-1:0] m_inj_q[$];
  logic [DS-5:0] m_ej_q[$];
  logic          m_inj_valid;
  logic [DS-1:0] m_inj_data;
  logic          m_ovf;
  logic          m_mis;
  logic [15:0]   m_tx_cnt;
  logic [15:0]   m_rx_cnt;

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    bit accept;
    bit pop;
    bit room;
    if (rst) begin
      m_inj_q.delete();
      m_ej_q.delete();
      m_inj_valid = 1'b0;
      m_inj_data  = '0;
      m_ovf       = 1'b0;
      m_mis       = 1'b0;
      m_tx_cnt    = '0;
      m_rx_cnt    = '0;
      return;
    end
    accept = tx_valid && (m_inj_q.size() < IDP);
    if (m_inj_q.size() > 0 && !router_full) begin
      m_inj_valid = 1'b1;
      m_inj_data  = m_inj_q.pop_front();
      m_tx_cnt    = m_tx_cnt + 16'd1;
    end else begin
      m_inj_valid = 1'b0;
    end
    if (accept) m_inj_q.push_back(mkflit(tx_dest, 4'(NID), tx_payload));

    pop  = (m_ej_q.size() > 0) && rx_ready;
    room = m_ej_q.size() < EDP;
    if (pop) begin
      void'(m_ej_q.pop_front());
      m_rx_cnt = m_rx_cnt + 16'd1;
    end
    if (ej_valid) begin
      if (room || pop) m_ej_q.push_back(ej_data[DS-5:0]);
      else             m_ovf = 1'b1;
      if (ej_data[DS-1:DS-4] != 4'(NID)) m_mis = 1'b1;
    end
  endfunction

  task automatic check_all();
    chk("tx_ready", 32'(tx_ready), 32'(m_inj_q.size() < IDP));
    chk("inj_valid", 32'(inj_valid), 32'(m_inj_valid));
    chk("inj_data", 32'(inj_data), 32'(m_inj_data));
    chk("rx_valid", 32'(rx_valid), 32'(m_ej_q.size() > 0));
    if (m_ej_q.size() > 0) begin
      chk("rx_src", 32'(rx_src), 32'(m_ej_q[0][DS-5:DS-8]));
      chk("rx_payload", 32'(rx_payload), 32'(m_ej_q[0][PW-1:0]));
    end
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_misroute", 32'(err_misroute), 32'(m_mis));
    chk("tx_cnt", 32'(tx_cnt), 32'(m_tx_cnt));
    chk("rx_cnt", 32'(rx_cnt), 32'(m_rx_cnt));
  endtask

  task automatic tick(input bit do_chk);
    model_edge();
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle();
    rst = 0; tx_valid = 0; tx_dest = '0; tx_payload = '0; router_full = 0;
    ej_valid = 0; ej_data = '0; rx_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(1);
    rst = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            rst;
    bit            txv;
    bit            rf;
    logic [3:0]    dest;
    logic [PW-1:0] pl;
    bit            e_rdy;
    bit            e_iv;
    logic [DS-1:0] e_data;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t       tbl[15];
  logic [3:0] exp_src[3];
  int         n;
  logic [PW-1:0] last_pl;

  initial begin
    idle();
    exp_src[0] = 4'd2; exp_src[1] = 4'd9; exp_src[2] = 4'd15;

    // Reset, single inject, then reset and backpressure with five pushes.
    tbl[0]  = '{1, 0, 0, 4'h0, 22'h0,     1, 0, 30'h0, 16'd0};
    tbl[1]  = '{0, 1, 0, 4'h3, 22'h12345, 1, 0, 30'h0, 16'd0};
    tbl[2]  = '{0, 0, 0, 4'h0, 22'h0,     1, 1, mkflit(4'h3, 4'h6, 22'h12345), 16'd1};
    tbl[3]  = '{0, 0, 0, 4'h0, 22'h0,     1, 0, mkflit(4'h3, 4'h6, 22'h12345), 16'd1};
    tbl[4]  = '{1, 0, 0, 4'h0, 22'h0,     1, 0, 30'h0, 16'd0};
    tbl[5]  = '{0, 1, 1, 4'h1, 22'h1,     1, 0, 30'h0, 16'd0};
    tbl[6]  = '{0, 1, 1, 4'h2, 22'h2,     1, 0, 30'h0, 16'd0};
    tbl[7]  = '{0, 1, 1, 4'h3, 22'h3,     1, 0, 30'h0, 16'd0};
    tbl[8]  = '{0, 1, 1, 4'h4, 22'h4,     0, 0, 30'h0, 16'd0};
    tbl[9]  = '{0, 1, 1, 4'h5, 22'h5,     0, 0, 30'h0, 16'd0};
    tbl[10] = '{0, 0, 0, 4'h0, 22'h0,     1, 1, mkflit(4'h1, 4'h6, 22'h1), 16'd1};
    tbl[11] = '{0, 0, 0, 4'h0, 22'h0,     1, 1, mkflit(4'h2, 4'h6, 22'h2), 16'd2};
    tbl[12] = '{0, 0, 0, 4'h0, 22'h0,     1, 1, mkflit(4'h3, 4'h6, 22'h3), 16'd3};
    tbl[13] = '{0, 0, 0, 4'h0, 22'h0,     1, 1, mkflit(4'h4, 4'h6, 22'h4), 16'd4};
    tbl[14] = '{0, 0, 0, 4'h0, 22'h0,     1, 0, mkflit(4'h4, 4'h6, 22'h4), 16'd4};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; tx_valid = tbl[i].txv; router_full = tbl[i].rf;
      tx_dest = tbl[i].dest; tx_payload = tbl[i].pl;
      tick(1);
      chk($sformatf("tbl%0d_tx_ready", i), 32'(tx_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_inj_valid", i), 32'(inj_valid), 32'(tbl[i].e_iv));
      chk($sformatf("tbl%0d_inj_data", i), 32'(inj_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_tx_cnt", i), 32'(tx_cnt), 32'(tbl[i].e_cnt));
      $display("vec %0d: tx_ready=%0d inj_valid=%0d inj_data=0x%0h tx_cnt=%0d",
               i, tx_ready, inj_valid, inj_data, tx_cnt);
    end

    // Ejection delivery in arrival order.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ej_valid = 1; ej_data = mkflit(4'h6, exp_src[i], 22'(100 + i));
      tick(1);
    end
    ej_valid = 0;
    chk("deliv_rx_valid", 32'(rx_valid), 32'd1);
    chk("deliv_first_src", 32'(rx_src), 32'd2);
    rx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("deliv_src%0d", i), 32'(rx_src), 32'(exp_src[i]));
      $display("deliver %0d: rx_src=%0d rx_payload=0x%0h", i, rx_src, rx_payload);
      tick(1);
    end
    rx_ready = 0;
    chk("deliv_rx_cnt", 32'(rx_cnt), 32'd3);
    chk("deliv_err_ovf", 32'(err_overflow), 32'd0);
    chk("deliv_err_mis", 32'(err_misroute), 32'd0);

    // Overflow: fifth flit dropped.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ej_valid = 1; ej_data = mkflit(4'h6, 4'h1, 22'(200 + i));
      tick(1);
    end
    ej_valid = 0;
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    rx_ready = 1; n = 0;
    while (rx_valid && n < 10) begin
      tick(1);
      n++;
    end
    rx_ready = 0;
    chk("ovf_drained", 32'(n), 32'd4);
    $display("overflow: err_overflow=%0d drained=%0d", err_overflow, n);

    // Overflow variant: a pop in the same cycle makes room for the fifth flit.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ej_valid = 1; ej_data = mkflit(4'h6, 4'h1, 22'(300 + i));
      rx_ready = (i == 4);
      tick(1);
    end
    ej_valid = 0; rx_ready = 0;
    chk("ovf_var_flag", 32'(err_overflow), 32'd0);
    rx_ready = 1; n = 0; last_pl = '0;
    while (rx_valid && n < 10) begin
      last_pl = rx_payload;
      tick(1);
      n++;
    end
    rx_ready = 0;
    chk("ovf_var_drained", 32'(n), 32'd4);
    chk("ovf_var_last", 32'(last_pl), 32'd304);
    chk("ovf_var_rx_cnt", 32'(rx_cnt), 32'd5);
    $display("overflow variant: err_overflow=%0d drained=%0d rx_cnt=%0d", err_overflow, n, rx_cnt);

    // Misrouted flit still delivered intact.
    do_reset();
    ej_valid = 1; ej_data = mkflit(4'h5, 4'h3, 22'h2AAAAA);
    tick(1);
    ej_valid = 0;
    chk("mis_flag", 32'(err_misroute), 32'd1);
    chk("mis_rx_valid", 32'(rx_valid), 32'd1);
    chk("mis_payload", 32'(rx_payload), 32'h2AAAAA);
    chk("mis_src", 32'(rx_src), 32'd3);
    rx_ready = 1;
    tick(1);
    rx_ready = 0;
    chk("mis_sticky", 32'(err_misroute), 32'd1);
    $display("misroute: err_misroute=%0d rx_cnt=%0d", err_misroute, rx_cnt);

    // Reset with traffic queued on both sides.
    do_reset();
    router_full = 1;
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1; tx_dest = 4'(i + 1); tx_payload = 22'(400 + i);
      ej_valid = 1; ej_data = mkflit(4'h6, 4'h2, 22'(500 + i));
      tick(1);
    end
    idle();
    router_full = 1;
    rst = 1;
    tick(1);
    rst = 0; router_full = 0;
    chk("rstmid_inj_valid", 32'(inj_valid), 32'd0);
    chk("rstmid_rx_valid", 32'(rx_valid), 32'd0);
    chk("rstmid_tx_ready", 32'(tx_ready), 32'd1);
    tick(1);
    chk("rstmid_no_stale", 32'(inj_valid), 32'd0);
    $display("reset mid-traffic: inj_valid=%0d rx_valid=%0d tx_ready=%0d", inj_valid, rx_valid, tx_ready);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tx_valid    = 1'($urandom_range(1, 0));
      tx_dest     = 4'($urandom_range(15, 0));
      tx_payload  = PW'($urandom);
      router_full = ($urandom_range(3, 0) == 0);
      ej_valid    = ($urandom_range(2, 0) == 0);
      ej_data     = mkflit(($urandom_range(7, 0) == 0) ? 4'h9 : 4'h6,
                           4'($urandom_range(15, 0)), PW'($urandom));
      rx_ready    = ($urandom_range(2, 0) != 0);
      tick(1);
    end
    idle();
    $display("random: tx_cnt=%0d rx_cnt=%0d errors=%0d", tx_cnt, rx_cnt, errors);

    // Counter wrap after 65537 injections.
    do_reset();
    tx_valid = 1; tx_dest = 4'h2;
    for (int i = 0; i < 65537; i++) begin
      tx_payload = PW'(i);
      tick(0);
    end
    tx_valid = 0;
    tick(0);
    tick(1);
    chk("wrap_tx_cnt", 32'(tx_cnt), 32'd1);
    $display("wrap: tx_cnt=%0d", tx_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
